// File: rtl/cpu_control_unit.sv
// cpu_control_unit: multi-cycle FETCH/DECODE/EXEC/HALT sequencer for the
// 16-bit CPU datapath. It owns the PC and the instruction register, and it
// drives the datapath control lines from the current state and IR.
// Optional feature macro: CU_ILLEGAL_TRAP_EN. When it is defined, op 0xE sets a
// sticky illegal flag and halts. When it is undefined, op 0xE is a NOP and
// illegal is tied low.
module cpu_control_unit #(
  parameter int BUS_W   = 16,
  parameter int ADDR_W  = 4,
  parameter int FS_W    = 3,
  parameter int MADDR_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  output logic               rom_req,
  output logic [BUS_W-1:0]   rom_addr,
  input  logic               rom_ack,
  input  logic [BUS_W-1:0]   rom_data,
  output logic               mem_req,
  output logic [MADDR_W-1:0] mem_addr,
  input  logic               mem_ack,
  input  logic [BUS_W-1:0]   dp_dout,
  input  logic               resume,
  output logic [BUS_W-1:0]   pc,
  output logic [ADDR_W-1:0]  da,
  output logic [ADDR_W-1:0]  aa,
  output logic [ADDR_W-1:0]  ba,
  output logic [FS_W-1:0]    fs,
  output logic               mb,
  output logic               md,
  output logic               bl,
  output logic               rw,
  output logic               halted,
  output logic               illegal
);

  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;

  state_t             state, state_nx;
  logic [BUS_W-1:0]   pc_r, pc_nx;
  logic [BUS_W-1:0]   ir, ir_nx;
  logic               run;   // low only during the first cycle after reset
  logic [3:0]         op;

  assign op = ir[BUS_W-1 -: 4];

`ifdef CU_ILLEGAL_TRAP_EN
  logic ill_r, ill_nx;

  // Sticky illegal-opcode flag, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ill_r <= 1'b0;
    else       ill_r <= ill_nx;
  end

  assign illegal = ill_r;
`else
  assign illegal = 1'b0;
`endif

  // State, PC, IR and the post-reset start flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
      pc_r  <= '0;
      ir    <= '0;
      run   <= 1'b0;
    end else begin
      state <= state_nx;
      pc_r  <= pc_nx;
      ir    <= ir_nx;
      run   <= 1'b1;
    end
  end

  // Next-state, PC/IR update and control decode for the current state
  always_comb begin
    state_nx = state;
    pc_nx    = pc_r;
    ir_nx    = ir;
`ifdef CU_ILLEGAL_TRAP_EN
    ill_nx   = ill_r;
`endif
    rom_req  = 1'b0;
    mem_req  = 1'b0;
    rw       = 1'b0;
    mb       = 1'b0;
    md       = 1'b0;
    bl       = 1'b0;
    fs       = '0;
    case (state)
      S_FETCH: begin
        // Holding rom_req off for one cycle keeps every output low while in reset
        rom_req = run;
        if (run && rom_ack) begin
          ir_nx    = rom_data;
          pc_nx    = pc_r + BUS_W'(1);
          state_nx = S_DECODE;
        end
      end
      S_DECODE: state_nx = S_EXEC;
      S_EXEC: begin
        state_nx = S_FETCH;
        case (op)
          4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
            fs = ir[12 +: FS_W];
            mb = 1'b1;
            md = 1'b1;
            bl = 1'b1;
            rw = 1'b1;
          end
          4'h8: begin  // immediate form: mb=0 selects BA as zero-extended imm4
            md = 1'b1;
            bl = 1'b1;
            rw = 1'b1;
          end
          4'h9: begin  // load: stay in EXEC until RAM answers, write on the ack cycle
            mem_req = 1'b1;
            bl      = 1'b1;
            if (mem_ack) rw = 1'b1;
            else         state_nx = S_EXEC;
          end
          4'hA: begin  // pc already points past JAL, so it is the return address
            md    = 1'b1;
            rw    = 1'b1;
            pc_nx = {pc_r[BUS_W-1:8], ir[7:0]};
          end
          4'hB: begin
            if (dp_dout == '0)
              pc_nx = pc_r + {{(BUS_W-8){ir[7]}}, ir[7:0]};
          end
          4'hC: pc_nx = {pc_r[BUS_W-1:12], ir[11:0]};
          4'hD: rw = 1'b1;  // md=bl=0 selects the constant 0
          4'hE: begin
`ifdef CU_ILLEGAL_TRAP_EN
            ill_nx   = 1'b1;
            state_nx = S_HALT;
`endif
          end
          4'hF: state_nx = S_HALT;
        endcase
      end
      S_HALT: if (resume) state_nx = S_FETCH;
      default: state_nx = S_FETCH;
    endcase
  end

  assign rom_addr = pc_r;
  assign pc       = pc_r;
  assign mem_addr = ir[MADDR_W-1:0];
  assign da       = ir[8 +: ADDR_W];
  assign aa       = ir[4 +: ADDR_W];
  assign ba       = ir[0 +: ADDR_W];
  assign halted   = (state == S_HALT);

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit. It runs one linear sequence of
// instructions with hand-computed expected PCs and control values.
module tb_cpu_control_unit;

  logic        clk, reset;
  logic        rom_req, rom_ack;
  logic [15:0] rom_addr, rom_data;
  logic        mem_req, mem_ack;
  logic [7:0]  mem_addr;
  logic [15:0] dp_dout, pc;
  logic        resume;
  logic [3:0]  da, aa, ba;
  logic [2:0]  fs;
  logic        mb, md, bl, rw, halted, illegal;

  int checks = 0;
  int errors = 0;

  cpu_control_unit dut (
    .clk(clk), .reset(reset),
    .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack), .rom_data(rom_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .dp_dout(dp_dout), .resume(resume), .pc(pc),
    .da(da), .aa(aa), .ba(ba), .fs(fs), .mb(mb), .md(md), .bl(bl), .rw(rw),
    .halted(halted), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present one instruction with an immediate ack; the DUT ends up in DECODE
  task automatic fetch(input logic [15:0] w);
    rom_data = w;
    rom_ack  = 1'b1;
    step();
    rom_ack  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rom_ack = 1'b0; rom_data = '0; mem_ack = 1'b0;
    dp_dout = '0; resume = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_rom_req", rom_req, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_rw", rw, 0);
    chk("rst_pc", pc, 0);
    chk("rst_ctl", {mb, md, bl, fs, da, aa, ba, halted, illegal}, 0);

    reset = 1'b0;
    step();
    chk("first_rom_req", rom_req, 1);
    chk("first_rom_addr", rom_addr, 16'h0000);

    // ALU 0x0123 with two ROM wait cycles
    step(); step();
    chk("wait_rom_req", rom_req, 1);
    fetch(16'h0123);
    chk("alu_dec_rw", rw, 0);
    chk("alu_dec_da", da, 1);
    chk("alu_pc", pc, 16'h0001);
    chk("alu_dec_rom_req", rom_req, 0);
    step();
    chk("alu_exec_rw", rw, 1);
    chk("alu_exec_ctl", {fs, mb, md, bl}, {3'd0, 3'b111});
    chk("alu_exec_abr", {da, aa, ba}, 12'h123);
    step();
    chk("alu_rw_one_cycle", rw, 0);
    chk("alu_next_addr", rom_addr, 16'h0001);

    // resume outside HALT must not disturb FETCH
    resume = 1'b1; step(); resume = 1'b0;
    chk("resume_ignored", {rom_req, rom_addr}, {1'b1, 16'h0001});

    // JMP to 0x010, then JAL 0xA720
    fetch(16'hC010); step(); step();
    chk("jmp_addr", rom_addr, 16'h0010);
    fetch(16'hA720); step();
    chk("jal_ctl", {rw, md, bl, da}, {3'b110, 4'd7});
    chk("jal_ret_pc", pc, 16'h0011);
    step();
    chk("jal_target", rom_addr, 16'h0020);

    // BZ 0xB5FE at pc=4, taken then not taken
    fetch(16'hC004); step(); step();
    chk("jmp4_addr", rom_addr, 16'h0004);
    dp_dout = 16'h0000;
    fetch(16'hB5FE); step();
    chk("bz_rw", rw, 0);
    step();
    chk("bz_taken", rom_addr, 16'h0003);
    fetch(16'hC004); step(); step();
    dp_dout = 16'h0001;
    fetch(16'hB5FE); step(); step();
    chk("bz_not_taken", rom_addr, 16'h0005);

    // backwards branch wraps below zero, then the fetch increment wraps to 0
    dp_dout = 16'h0000;
    fetch(16'hB0F9); step(); step();
    chk("bz_wrap", rom_addr, 16'hFFFF);
    fetch(16'h5123);
    chk("pc_wrap", pc, 16'h0000);
    step();
    chk("alu5_fs", {fs, rw}, {3'd5, 1'b1});
    step();
    chk("after_wrap_addr", rom_addr, 16'h0000);

    // LD 0x9340, mem_ack after 3 cycles
    fetch(16'h9340);
    chk("ld_dec_mem_req", mem_req, 0);
    step();
    chk("ld_wait0", {mem_req, mem_addr, rw, md, bl}, {1'b1, 8'h40, 3'b001});
    step();
    chk("ld_wait1", {mem_req, mem_addr, rw}, {1'b1, 8'h40, 1'b0});
    step();
    chk("ld_wait2", {mem_req, mem_addr, rw}, {1'b1, 8'h40, 1'b0});
    mem_ack = 1'b1;
    #1;
    chk("ld_ack", {mem_req, mem_addr, rw, md, bl}, {1'b1, 8'h40, 3'b101});
    step();
    mem_ack = 1'b0;
    chk("ld_done", {mem_req, rw, rom_req, rom_addr}, {3'b001, 16'h0001});

    // CLR and ALUI
    fetch(16'hD500); step();
    chk("clr_ctl", {rw, md, bl, da}, {3'b100, 4'd5});
    step();
    fetch(16'h8612); step();
    chk("alui_ctl", {rw, fs, mb, md, bl, ba}, {1'b1, 3'd0, 3'b011, 4'd2});
    step();
    chk("alui_next", rom_addr, 16'h0003);

    // op 0xE then HALT
    fetch(16'hE000); step();
    chk("e_rw", rw, 0);
    step();
`ifdef CU_ILLEGAL_TRAP_EN
    chk("trap_state", {illegal, halted, rom_req}, 3'b110);
    step();
    chk("trap_held", {illegal, halted, rom_req}, 3'b110);
    resume = 1'b1; step(); resume = 1'b0;
    chk("trap_resume", {illegal, halted, rom_req, rom_addr}, {3'b101, 16'h0004});
`else
    chk("e_nop", {illegal, halted, rom_req, rom_addr}, {3'b001, 16'h0004});
`endif
    fetch(16'hF000); step();
    chk("halt_exec_rw", rw, 0);
    step();
`ifdef CU_ILLEGAL_TRAP_EN
    chk("halt_state", {halted, rom_req, illegal}, 3'b101);
`else
    chk("halt_state", {halted, rom_req, illegal}, 3'b100);
`endif
    step();
    chk("halt_held", {halted, rom_req, pc}, {2'b10, 16'h0005});
    resume = 1'b1; step(); resume = 1'b0;
    chk("halt_resume", {halted, rom_req, rom_addr}, {2'b01, 16'h0005});

    // reset in the middle of a load
    fetch(16'h9340); step();
    chk("abort_pre", mem_req, 1);
    reset = 1'b1;
    #1;
    chk("abort_async", {mem_req, rw, rom_req, pc}, {3'b000, 16'h0000});
    step();
    chk("abort_edge", {mem_req, rw, pc, illegal, halted}, {2'b00, 16'h0000, 2'b00});
    reset = 1'b0;
    step();
    chk("abort_refetch", {rom_req, rom_addr}, {1'b1, 16'h0000});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
